mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 18 +
 rtl/mem_arbiter_if.sv | 37 +++
 rtl/mem_arbiter_pick.sv | 44 ++++
 rtl/mem_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types and default widths for the mem_arbiter slice
package mem_arbiter_pkg;

  localparam int ADDR_W_DEF = 28;
  localparam int LINE_W_DEF = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - I-cache, D-cache and memory port bundle of mem_arbiter
interface mem_arbiter_if import mem_arbiter_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LINE_W = LINE_W_DEF
);

  logic              ic_read;
  logic [ADDR_W-1:0] ic_addr;
  logic [LINE_W-1:0] ic_rdata;
  logic              ic_ready;

  logic              dc_read;
  logic              dc_write;
  logic [ADDR_W-1:0] dc_addr;
  logic [LINE_W-1:0] dc_wdata;
  logic [LINE_W-1:0] dc_rdata;
  logic              dc_ready;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_ready;

  // slave: the arbiter; master: the caches plus the memory behind it
  modport slave (
    input  ic_read, ic_addr, dc_read, dc_write, dc_addr, dc_wdata, mem_rdata, mem_ready,
    output ic_rdata, ic_ready, dc_rdata, dc_ready, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output ic_read, ic_addr, dc_read, dc_write, dc_addr, dc_wdata, mem_rdata, mem_ready,
    input  ic_rdata, ic_ready, dc_rdata, dc_ready, mem_read, mem_write, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arbiter_pick.sv
// rtl/mem_arbiter_pick.sv - grant selection between I-cache and D-cache requests
// MEM_ARBITER_RR_EN selects round-robin with a pointer flop; otherwise D always wins.
module mem_arbiter_pick import mem_arbiter_pkg::*; (
`ifdef MEM_ARBITER_RR_EN
  input  logic   clk,
  input  logic   rst,
  input  logic   take,
`endif
  input  logic   ic_req,
  input  logic   dc_req,
  output owner_t grant
);

`ifdef MEM_ARBITER_RR_EN
  owner_t ptr_q;
  owner_t ptr_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= OWN_D;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // The pointer only moves when a grant is actually taken, and then points away from it.
  always_comb begin
    if (ic_req && dc_req) begin
      grant = ptr_q;
    end else if (dc_req) begin
      grant = OWN_D;
    end else begin
      grant = OWN_I;
    end
    ptr_d = ptr_q;
    if (take) begin
      ptr_d = (grant == OWN_D) ? OWN_I : OWN_D;
    end
  end
`else
  assign grant = (dc_req || !ic_req) ? OWN_D : OWN_I;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one memory port between I-cache fills and D-cache reads/writes
// Define MEM_ARBITER_RR_EN for round-robin between simultaneous requests.
module mem_arbiter import mem_arbiter_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LINE_W = LINE_W_DEF
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  owner_t            grant;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [LINE_W-1:0] ic_rdata_q, ic_rdata_d;
  logic [LINE_W-1:0] dc_rdata_q, dc_rdata_d;
  logic              ic_ready_q, ic_ready_d;
  logic              dc_ready_q, dc_ready_d;
  logic              any_req;

  assign any_req = bus.ic_read | bus.dc_read | bus.dc_write;

  mem_arbiter_pick u_pick (
`ifdef MEM_ARBITER_RR_EN
    .clk   (clk),
    .rst   (rst),
    .take  ((state_q == IDLE) && any_req),
`endif
    .ic_req(bus.ic_read),
    .dc_req(bus.dc_read | bus.dc_write),
    .grant (grant)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_D;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ic_rdata_q  <= '0;
      dc_rdata_q  <= '0;
      ic_ready_q  <= 1'b0;
      dc_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ic_rdata_q  <= ic_rdata_d;
      dc_rdata_q  <= dc_rdata_d;
      ic_ready_q  <= ic_ready_d;
      dc_ready_q  <= dc_ready_d;
    end
  end

  // DONE never samples requests, so a requester still holding after ready is not re-served.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = BUSY;
      BUSY:    if (bus.mem_ready) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    owner_d     = owner_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    ic_rdata_d  = ic_rdata_q;
    dc_rdata_d  = dc_rdata_q;
    ic_ready_d  = 1'b0;
    dc_ready_d  = 1'b0;
    if ((state_q == IDLE) && any_req) begin
      owner_d = grant;
      if (grant == OWN_D) begin
        // read+write together is a write
        mem_write_d = bus.dc_write;
        mem_read_d  = ~bus.dc_write;
        mem_addr_d  = bus.dc_addr;
        mem_wdata_d = bus.dc_wdata;
      end else begin
        mem_write_d = 1'b0;
        mem_read_d  = 1'b1;
        mem_addr_d  = bus.ic_addr;
      end
    end
    if ((state_q == BUSY) && bus.mem_ready) begin
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
      if (owner_q == OWN_D) begin
        dc_ready_d = 1'b1;
        if (mem_read_q) dc_rdata_d = bus.mem_rdata;
      end else begin
        ic_ready_d = 1'b1;
        if (mem_read_q) ic_rdata_d = bus.mem_rdata;
      end
    end
  end

  assign bus.mem_read  = mem_read_q;
  assign bus.mem_write = mem_write_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.ic_rdata  = ic_rdata_q;
  assign bus.ic_ready  = ic_ready_q;
  assign bus.dc_rdata  = dc_rdata_q;
  assign bus.dc_ready  = dc_ready_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized scoreboard bench for mem_arbiter (either MEM_ARBITER_RR_EN build)
`timescale 1ns/1ps
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int AW = ADDR_W_DEF;
  localparam int LW = LINE_W_DEF;
`ifdef MEM_ARBITER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    bit          wr;
    logic [LW-1:0] data;
  } dc_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [LW-1:0] exp_ic[$];
  dc_exp_t       exp_dc[$];
  owner_t        grant_log[$];
  dc_exp_t       dc_e;
  logic [LW-1:0] last_ic_line = '0;
  logic [LW-1:0] last_dc_line = '0;

  int            ic_issued = 0, ic_served = 0, dc_issued = 0, dc_served = 0;
  logic [AW-1:0] ic_out_addr = '0, dc_out_addr = '0;
  logic [LW-1:0] dc_out_wdata = '0;
  bit            dc_out_wr = 1'b0;

  int  mem_lat   = -1;
  bit  mem_stall = 1'b0;

  // Memory image: every line is a fixed function of its address.
  function automatic logic [LW-1:0] img(input logic [AW-1:0] a);
    logic [31:0] x;
    x = 32'(a);
    if (a == 28'h10) return 128'hA5;
    return {x ^ 32'h5A5A0000, ~x, x * 32'd2654435761, 32'hC0DE0000 | x};
  endfunction

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_mem_read"},  bus.mem_read, 0);
    chk({tag, "_mem_write"}, bus.mem_write, 0);
    chk({tag, "_mem_addr"},  bus.mem_addr, 0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
    chk({tag, "_ic_ready"},  bus.ic_ready, 0);
    chk({tag, "_dc_ready"},  bus.dc_ready, 0);
    chk({tag, "_ic_rdata"},  bus.ic_rdata, 0);
    chk({tag, "_dc_rdata"},  bus.dc_rdata, 0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Requester tasks start and end at posedge+1.
  task automatic ic_txn(input logic [AW-1:0] addr, input bit drop_early);
    bit got = 1'b0;
    exp_ic.push_back(img(addr));
    ic_out_addr = addr;
    ic_issued++;
    bus.ic_read = 1'b1;
    bus.ic_addr = addr;
    for (int c = 0; c < 400 && !got; c++) begin
      @(negedge clk);
      if (bus.ic_ready) got = 1'b1;
      else if (drop_early && c == 1) begin
        @(posedge clk);
        #1;
        bus.ic_read = 1'b0;
      end
    end
    chk("ic_txn_timeout", got, 1);
    @(posedge clk);
    #1;
    bus.ic_read = 1'b0;
  endtask

  task automatic dc_txn(input bit wr, input bit both, input logic [AW-1:0] addr, input logic [LW-1:0] wdata);
    bit got = 1'b0;
    dc_exp_t e;
    e.wr   = wr;
    e.data = wr ? '0 : img(addr);
    exp_dc.push_back(e);
    dc_out_wr    = wr;
    dc_out_addr  = addr;
    dc_out_wdata = wdata;
    dc_issued++;
    bus.dc_write = wr;
    bus.dc_read  = !wr || both;
    bus.dc_addr  = addr;
    bus.dc_wdata = wdata;
    for (int c = 0; c < 400 && !got; c++) begin
      @(negedge clk);
      if (bus.dc_ready) got = 1'b1;
    end
    chk("dc_txn_timeout", got, 1);
    @(posedge clk);
    #1;
    bus.dc_read  = 1'b0;
    bus.dc_write = 1'b0;
  endtask

  // Response monitor: pops expected lines whenever a ready appears.
  bit ic_rdy_prev = 1'b0, dc_rdy_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      ic_rdy_prev  = 1'b0;
      dc_rdy_prev  = 1'b0;
      last_ic_line = '0;
      last_dc_line = '0;
    end else begin
      if (bus.ic_ready) begin
        chk("ic_ready_expected", exp_ic.size() != 0, 1);
        if (exp_ic.size() != 0) begin
          last_ic_line = exp_ic.pop_front();
          chk("ic_rdata", bus.ic_rdata, last_ic_line);
        end
        chk("ic_ready_width", ic_rdy_prev, 0);
        chk("dc_ready_nonowner", bus.dc_ready, 0);
      end else begin
        chk("ic_rdata_hold", bus.ic_rdata, last_ic_line);
      end
      if (bus.dc_ready) begin
        chk("dc_ready_expected", exp_dc.size() != 0, 1);
        if (exp_dc.size() != 0) begin
          dc_e = exp_dc.pop_front();
          if (dc_e.wr) chk("dc_rdata_after_write", bus.dc_rdata, last_dc_line);
          else begin
            chk("dc_rdata", bus.dc_rdata, dc_e.data);
            last_dc_line = dc_e.data;
          end
        end
        chk("dc_ready_width", dc_rdy_prev, 0);
      end else begin
        chk("dc_rdata_hold", bus.dc_rdata, last_dc_line);
      end
      ic_rdy_prev = bus.ic_ready;
      dc_rdy_prev = bus.dc_ready;
    end
  end

  // Memory model: predicts the grant from the requests seen one edge earlier, then answers.
  int            r_st = 0, r_cnt = 0;
  bit            prev_ic = 1'b0, prev_dc = 1'b0, mi, md, r_wr = 1'b0;
  owner_t        w, r_own = OWN_D, rr_ptr = OWN_D;
  logic [AW-1:0] r_addr = '0;
  logic [LW-1:0] r_wdata = '0;
  bit            rdy_nxt = 1'b0;
  logic [LW-1:0] rdata_nxt = '0;

  task automatic hold_check();
    chk("mem_addr_stable",  bus.mem_addr, r_addr);
    chk("mem_wdata_stable", bus.mem_wdata, r_wdata);
    chk("mem_op_stable",    {bus.mem_read, bus.mem_write}, {!r_wr, r_wr});
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      r_st    = 0;
      rdy_nxt = 1'b0;
      rr_ptr  = OWN_D;
    end else begin
      case (r_st)
        0: if (bus.mem_read || bus.mem_write) begin
          chk("mem_req_has_requester", prev_ic | prev_dc, 1);
          w  = (prev_ic && prev_dc) ? (RR ? rr_ptr : OWN_D) : (prev_dc ? OWN_D : OWN_I);
          mi = (ic_issued > ic_served) && bus.mem_read && !bus.mem_write && (bus.mem_addr == ic_out_addr);
          md = (dc_issued > dc_served) && (bus.mem_write == dc_out_wr) && (bus.mem_read == !dc_out_wr)
               && (bus.mem_addr == dc_out_addr) && (!dc_out_wr || bus.mem_wdata == dc_out_wdata);
          chk("mem_req_matches_grant", (w == OWN_D) ? md : mi, 1);
          if (w == OWN_D) dc_served++;
          else ic_served++;
          grant_log.push_back(md ? OWN_D : OWN_I);
          rr_ptr  = (w == OWN_D) ? OWN_I : OWN_D;
          r_own   = w;
          r_addr  = bus.mem_addr;
          r_wdata = bus.mem_wdata;
          r_wr    = bus.mem_write;
          r_cnt   = (mem_lat >= 0) ? mem_lat : int'($urandom_range(0, 4));
          r_st    = 1;
        end
        1: begin
          hold_check();
          if (!mem_stall) begin
            if (r_cnt == 0) begin
              rdy_nxt   = 1'b1;
              rdata_nxt = r_wr ? {$urandom, $urandom, $urandom, $urandom} : img(r_addr);
              r_st      = 2;
            end else r_cnt--;
          end
        end
        2: begin
          hold_check();
          r_st = 3;
        end
        default: begin
          chk("mem_req_drop", {bus.mem_read, bus.mem_write}, 0);
          chk("owner_ready", (r_own == OWN_D) ? bus.dc_ready : bus.ic_ready, 1);
          rdy_nxt = 1'b0;
          r_st    = 0;
        end
      endcase
    end
    prev_ic = bus.ic_read;
    prev_dc = bus.dc_read | bus.dc_write;
  end

  always @(posedge clk) begin
    #1;
    bus.mem_ready = rdy_nxt;
    bus.mem_rdata = rdata_nxt;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit seen;
    bus.ic_read  = 1'b0;
    bus.ic_addr  = '0;
    bus.dc_read  = 1'b0;
    bus.dc_write = 1'b0;
    bus.dc_addr  = '0;
    bus.dc_wdata = '0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(2);

    // I-cache fill with one-cycle request latency check
    mem_lat = 2;
    fork
      ic_txn(28'h10, 1'b0);
      begin
        @(negedge clk);
        chk("ic_lat_before", bus.mem_read, 0);
        @(negedge clk);
        chk("ic_lat_mem_read", bus.mem_read, 1);
        chk("ic_lat_mem_addr", bus.mem_addr, 28'h10);
      end
    join
    idle(2);
    dc_txn(1'b0, 1'b0, 28'h150, '0);
    idle(1);
    mem_lat = 3;
    dc_txn(1'b1, 1'b0, 28'h3F, 128'h1234);
    idle(1);
    dc_txn(1'b1, 1'b1, 28'h2AB, {$urandom, $urandom, $urandom, $urandom});
    idle(1);
    ic_txn(28'h22, 1'b1);
    idle(2);

    // Both requesters continuously asking
    grant_log.delete();
    mem_lat = 1;
    fork
      repeat (4) ic_txn(AW'($urandom_range(0, 4095)), 1'b0);
      repeat (4) dc_txn(1'b0, 1'b0, AW'(32'h1000 + $urandom_range(0, 4095)), '0);
    join
    chk("grant_order_count", grant_log.size() >= 4, 1);
    for (int i = 0; i < 4; i++) begin
      if (i < grant_log.size()) chk("grant_order", grant_log[i], (RR && (i % 2 == 1)) ? OWN_I : OWN_D);
    end
    idle(2);

    // Random traffic
    mem_lat = -1;
    fork
      for (int k = 0; k < 25; k++) begin
        ic_txn(AW'($urandom_range(0, 4095)), 1'b0);
        idle($urandom_range(0, 3));
      end
      for (int k = 0; k < 25; k++) begin
        if ($urandom_range(0, 2) == 0)
          dc_txn(1'b1, 1'($urandom_range(0, 1)), AW'(32'h2000 + $urandom_range(0, 4095)),
                 {$urandom, $urandom, $urandom, $urandom});
        else
          dc_txn(1'b0, 1'b0, AW'(32'h1000 + $urandom_range(0, 4095)), '0);
        idle($urandom_range(0, 3));
      end
    join
    idle(3);

    // Reset in the middle of a transaction
    mem_stall   = 1'b1;
    ic_out_addr = 28'h77;
    ic_issued++;
    bus.ic_read = 1'b1;
    bus.ic_addr = 28'h77;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      seen = bus.mem_read;
    end
    chk("rst_test_busy", seen, 1);
    #1;
    rst = 1'b0;
    #1;
    check_all_zero("async_reset");
    bus.ic_read = 1'b0;
    idle(2);
    rst       = 1'b1;
    mem_stall = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("post_rst_ic_ready", bus.ic_ready, 0);
      chk("post_rst_dc_ready", bus.dc_ready, 0);
      chk("post_rst_mem_req",  {bus.mem_read, bus.mem_write}, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
